// File: rtl/alu_result_log.sv
// alu_result_log: circular history of ALU results {C,Flags} with browse
// controls and a registered display mux (live value or selected entry).
// Optional feature macro: ALU_LOG_CLEAR_EN adds a synchronous 'clear' input.
module alu_result_log #(
    parameter int DEPTH = 8,
    parameter int DW    = 16,
    parameter int FW    = 5
) (
    input  logic                       CLOCK_50,
    input  logic                       reset,
    input  logic                       capture,
    input  logic [DW-1:0]              C,
    input  logic [FW-1:0]              Flags,
    input  logic                       browse_prev,
    input  logic                       browse_next,
    input  logic                       live_sel,
`ifdef ALU_LOG_CLEAR_EN
    input  logic                       clear,
`endif
    output logic [DW-1:0]              disp_value,
    output logic [FW-1:0]              disp_flags,
    output logic [$clog2(DEPTH)-1:0]   disp_index,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       hist_valid,
    output logic                       overflow
);

    localparam int AW = $clog2(DEPTH);

    logic [DW+FW-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW:0]      r_count;
    logic [AW-1:0]    r_view_off;
    logic             r_overflow;

    logic             w_clear;
    logic             w_full;
    logic             w_can_prev;
    logic [AW-1:0]    w_rd_addr;
    logic [DW+FW-1:0] w_rd_data;

`ifdef ALU_LOG_CLEAR_EN
    assign w_clear = clear;
`else
    assign w_clear = 1'b0;
`endif

    assign w_full     = (r_count == (AW+1)'(DEPTH));
    // Stepping older is allowed while view_off+1 still addresses a valid entry
    assign w_can_prev = (({1'b0, r_view_off} + (AW+1)'(1)) < r_count);
    // Newest entry sits just behind the write pointer; wrap is natural
    assign w_rd_addr  = r_wr_ptr - AW'(1) - r_view_off;
    assign w_rd_data  = r_mem[w_rd_addr];

    // History storage write; contents need no reset since count gates validity
    always_ff @(posedge CLOCK_50) begin
        if (capture && !w_clear) begin
            r_mem[r_wr_ptr] <= {C, Flags};
        end
    end

    // Pointer, occupancy, browse offset and sticky overflow bookkeeping
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_view_off <= '0;
            r_overflow <= 1'b0;
        end else if (w_clear) begin
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_view_off <= '0;
            r_overflow <= 1'b0;
        end else if (capture) begin
            r_wr_ptr   <= r_wr_ptr + AW'(1);
            r_view_off <= '0;
            if (w_full) begin
                r_overflow <= 1'b1;
            end else begin
                r_count <= r_count + (AW+1)'(1);
            end
        end else if (browse_prev && !browse_next) begin
            if (w_can_prev) begin
                r_view_off <= r_view_off + AW'(1);
            end
        end else if (browse_next && !browse_prev) begin
            if (r_view_off != '0) begin
                r_view_off <= r_view_off - AW'(1);
            end
        end
    end

    // Registered display mux: live ALU output, empty history, or selected entry
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            disp_value <= '0;
            disp_flags <= '0;
            disp_index <= '0;
            hist_valid <= 1'b0;
        end else begin
            disp_index <= r_view_off;
            if (live_sel) begin
                disp_value <= C;
                disp_flags <= Flags;
                hist_valid <= 1'b0;
            end else if (r_count == '0) begin
                disp_value <= '0;
                disp_flags <= '0;
                hist_valid <= 1'b0;
            end else begin
                disp_value <= w_rd_data[DW+FW-1:FW];
                disp_flags <= w_rd_data[FW-1:0];
                hist_valid <= 1'b1;
            end
        end
    end

    assign count    = r_count;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_alu_result_log.sv
// Directed self-checking bench for alu_result_log (DEPTH=8, DW=16, FW=5).
module tb_alu_result_log;

    logic        CLOCK_50 = 1'b0;
    logic        reset = 1'b1;
    logic        capture = 1'b0;
    logic [15:0] C = '0;
    logic [4:0]  Flags = '0;
    logic        browse_prev = 1'b0;
    logic        browse_next = 1'b0;
    logic        live_sel = 1'b0;
`ifdef ALU_LOG_CLEAR_EN
    logic        clear = 1'b0;
`endif
    logic [15:0] disp_value;
    logic [4:0]  disp_flags;
    logic [2:0]  disp_index;
    logic [3:0]  count;
    logic        hist_valid;
    logic        overflow;

    int total = 0;
    int bad   = 0;

    alu_result_log #(.DEPTH(8), .DW(16), .FW(5)) dut (
        .CLOCK_50    (CLOCK_50),
        .reset       (reset),
        .capture     (capture),
        .C           (C),
        .Flags       (Flags),
        .browse_prev (browse_prev),
        .browse_next (browse_next),
        .live_sel    (live_sel),
`ifdef ALU_LOG_CLEAR_EN
        .clear       (clear),
`endif
        .disp_value  (disp_value),
        .disp_flags  (disp_flags),
        .disp_index  (disp_index),
        .count       (count),
        .hist_valid  (hist_valid),
        .overflow    (overflow)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock edge; outputs are then sampled 1 time unit after it
    task automatic step();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic cap(input logic [15:0] v);
        C = v;
        Flags = v[4:0];
        capture = 1'b1;
        step();
        capture = 1'b0;
    endtask

    task automatic prev_n(input int n);
        for (int i = 0; i < n; i++) begin
            browse_prev = 1'b1;
            step();
            browse_prev = 1'b0;
            step();
        end
    endtask

    task automatic next_n(input int n);
        for (int i = 0; i < n; i++) begin
            browse_next = 1'b1;
            step();
            browse_next = 1'b0;
            step();
        end
    endtask

    initial begin
        // 1. Reset state with empty history
        do_reset();
        step();
        chk("rst_value", 32'(disp_value), 32'h0000);
        chk("rst_flags", 32'(disp_flags), 32'h00);
        chk("rst_hvalid", 32'(hist_valid), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_index", 32'(disp_index), 32'd0);

        // 2. Live pass-through
        live_sel = 1'b1;
        C = 16'h1234;
        Flags = 5'b10000;
        step();
        chk("live_value", 32'(disp_value), 32'h1234);
        chk("live_flags", 32'(disp_flags), 32'b10000);
        chk("live_hvalid", 32'(hist_valid), 32'd0);

        // 3. Three captures then browsing with saturation at both ends
        live_sel = 1'b0;
        cap(16'h0011);
        step();
        chk("cap1_latency", 32'(disp_value), 32'h0011);
        cap(16'h0022);
        cap(16'h0033);
        step();
        chk("cap3_count", 32'(count), 32'd3);
        chk("cap3_value", 32'(disp_value), 32'h0033);
        chk("cap3_flags", 32'(disp_flags), 32'b10011);
        chk("cap3_hvalid", 32'(hist_valid), 32'd1);
        prev_n(1);
        chk("prev1_value", 32'(disp_value), 32'h0022);
        chk("prev1_index", 32'(disp_index), 32'd1);
        prev_n(1);
        chk("prev2_value", 32'(disp_value), 32'h0011);
        chk("prev2_index", 32'(disp_index), 32'd2);
        prev_n(1);
        chk("prev_sat_value", 32'(disp_value), 32'h0011);
        chk("prev_sat_index", 32'(disp_index), 32'd2);
        next_n(3);
        chk("next3_value", 32'(disp_value), 32'h0033);
        chk("next3_index", 32'(disp_index), 32'd0);

        // 4. Fill to DEPTH, then overwrite the oldest entry
        do_reset();
        for (int v = 1; v <= 8; v++) cap(16'(v));
        chk("full_count", 32'(count), 32'd8);
        chk("full_noovf", 32'(overflow), 32'd0);
        cap(16'h0009);
        chk("ovf_count", 32'(count), 32'd8);
        chk("ovf_flag", 32'(overflow), 32'd1);
        step();
        chk("ovf_newest", 32'(disp_value), 32'h0009);
        prev_n(7);
        chk("ovf_oldest", 32'(disp_value), 32'h0002);
        chk("ovf_oldest_idx", 32'(disp_index), 32'd7);
        prev_n(1);
        chk("ovf_sat_value", 32'(disp_value), 32'h0002);
        chk("ovf_sat_index", 32'(disp_index), 32'd7);

        // 5. Capture beats browse; prev+next together is a no-op
        do_reset();
        chk("rst2_ovf", 32'(overflow), 32'd0);
        for (int v = 10; v <= 14; v++) cap(16'(v));
        prev_n(2);
        chk("pre_race_value", 32'(disp_value), 32'h000C);
        chk("pre_race_index", 32'(disp_index), 32'd2);
        C = 16'h000F;
        Flags = 5'h0F;
        capture = 1'b1;
        browse_prev = 1'b1;
        step();
        capture = 1'b0;
        browse_prev = 1'b0;
        step();
        chk("race_index", 32'(disp_index), 32'd0);
        chk("race_count", 32'(count), 32'd6);
        chk("race_value", 32'(disp_value), 32'h000F);
        prev_n(1);
        browse_prev = 1'b1;
        browse_next = 1'b1;
        step();
        browse_prev = 1'b0;
        browse_next = 1'b0;
        step();
        chk("both_index", 32'(disp_index), 32'd1);
        chk("both_value", 32'(disp_value), 32'h000E);
        // view offset survives a trip through live mode
        live_sel = 1'b1;
        C = 16'hBEEF;
        Flags = 5'b01010;
        step();
        chk("live2_value", 32'(disp_value), 32'hBEEF);
        chk("live2_index", 32'(disp_index), 32'd1);
        live_sel = 1'b0;
        step();
        chk("back_value", 32'(disp_value), 32'h000E);
        chk("back_hvalid", 32'(hist_valid), 32'd1);

        // 6. Asynchronous reset mid-browse
        do_reset();
        for (int v = 33; v <= 37; v++) cap(16'(v));
        prev_n(3);
        chk("pre_rst_index", 32'(disp_index), 32'd3);
        chk("pre_rst_value", 32'(disp_value), 32'h0022);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_value", 32'(disp_value), 32'h0000);
        chk("arst_flags", 32'(disp_flags), 32'h00);
        chk("arst_index", 32'(disp_index), 32'd0);
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_hvalid", 32'(hist_valid), 32'd0);
        chk("arst_ovf", 32'(overflow), 32'd0);
        step();
        reset = 1'b0;
        step();

`ifdef ALU_LOG_CLEAR_EN
        // Clear beats a simultaneous capture
        cap(16'h0101);
        cap(16'h0202);
        clear = 1'b1;
        C = 16'h0303;
        capture = 1'b1;
        step();
        clear = 1'b0;
        capture = 1'b0;
        chk("clr_count", 32'(count), 32'd0);
        step();
        chk("clr_hvalid", 32'(hist_valid), 32'd0);
        chk("clr_value", 32'(disp_value), 32'h0000);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_result_log.md
Name: alu_result_log

Overview:
Downstream stage of the ALU on the board top level. Captures the ALU result C and Flags into a circular history buffer on each capture pulse (the debounced commit/exec pulse). Lets the user browse older entries with prev/next pulses. Drives the 16-bit value and 5-bit flags that feed the hex4 display and LEDR[4:0], showing either the live ALU output or a selected history entry.

Parameters:
DEPTH, 8, number of history entries; power of two, minimum 2
DW, 16, data width of the ALU result
FW, 5, flag width ({Z,C,O,L,N})

Ports:
CLOCK_50  input  1  system clock, all logic on its rising edge
reset  input  1  asynchronous, active-high reset
capture  input  1  one-cycle pulse: log current C/Flags
C  input  DW  live ALU result
Flags  input  FW  live ALU flags
browse_prev  input  1  one-cycle pulse: step to an older entry
browse_next  input  1  one-cycle pulse: step to a newer entry
live_sel  input  1  level: 1 = show live ALU output, 0 = show history
disp_value  output  DW  registered value for the 7-seg display
disp_flags  output  FW  registered flags for the LEDs
disp_index  output  log2(DEPTH)  current browse offset (0 = newest)
count  output  log2(DEPTH)+1  number of valid entries, 0..DEPTH
hist_valid  output  1  1 when disp_value/disp_flags come from a valid history entry
overflow  output  1  sticky flag: an entry has been overwritten since reset

Behaviour:
- Reset (async assert, sync-safe deassert): wr_ptr=0, count=0, view_off=0, overflow=0; disp_value=0, disp_flags=0, disp_index=0, hist_valid=0. Buffer contents are don't-care.
- Capture at edge k:
  - Write {C,Flags} to mem[wr_ptr].
  - wr_ptr <= wr_ptr+1, modulo DEPTH, wrapping naturally.
  - If count<DEPTH, count <= count+1.
  - Otherwise count stays at DEPTH, the oldest entry is overwritten, and overflow <= 1 (sticky until reset).
  - view_off <= 0.
- Browse, only when no capture is in the same cycle:
  - browse_prev: view_off <= view_off+1, saturating at count-1. No change if count is 0.
  - browse_next: view_off <= view_off-1, saturating at 0.
  - prev and next together: no change.
  - Capture together with any browse pulse: capture wins and the browse pulse is dropped.
- Read address = (wr_ptr-1-view_off) mod DEPTH, computed from current registered state.
- Output register, updated every cycle (1-cycle latency from state to outputs):
  - live_sel=1: disp_value<=C, disp_flags<=Flags, hist_valid<=0.
  - live_sel=0, count=0: disp_value<=0, disp_flags<=0, hist_valid<=0.
  - live_sel=0, count>0: disp_value/disp_flags <= mem[read address], hist_valid<=1.
  - disp_index<=view_off in all cases.
- Timing: a capture at edge k is visible on the outputs after edge k+1 when live_sel=0. A browse pulse at edge k has the same latency.
- live_sel changes take effect on the next edge. view_off is preserved across live_sel toggles.
- Reset mid-browse or mid-capture clears everything immediately. No partial write survives.
- Storage may infer RAM or registers. The read path must not add latency beyond the single output register.

Optional Feature:
ALU_LOG_CLEAR_EN
- Defined: adds input port clear (1 bit, one-cycle pulse). Clear synchronously sets count=0, view_off=0, wr_ptr=0, overflow=0. Outputs follow the normal rules on the next edge, so disp is 0 if live_sel=0.
- Priority: clear beats capture and browse in the same cycle; the capture is dropped.
- Not defined: port absent; state is cleared only by reset.

Test Plan:
1. Reset, live_sel=0, no captures -> disp_value=0000, disp_flags=00000, hist_valid=0, count=0.
2. live_sel=1, C=1234, Flags=10000 -> next edge disp_value=1234, disp_flags=10000, hist_valid=0.
3. live_sel=0; capture C=0011,0022,0033 on separate cycles -> count=3, disp_value=0033. Then:
   - prev -> 0022, disp_index=1
   - prev -> 0011, disp_index=2
   - prev again -> stays 0011 (saturate)
   - next x3 -> 0033, disp_index=0.
4. DEPTH=8: capture 0001..0009 (9 captures) -> count=8, overflow=1. prev x7 -> disp_value=0002; prev again -> stays 0002; 0001 is lost.
5. view_off=2 with capture and browse_prev in the same cycle -> view_off=0, count+1, disp_value=new C. Separately, prev and next together -> view_off unchanged.
6. Assert reset while view_off=3, count=5 -> all outputs 0 immediately and overflow=0. With ALU_LOG_CLEAR_EN, clear and capture in the same cycle -> count=0, hist_valid=0.
